// File: rtl/fwd_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl_if
// Description : ID-stage request / forwarding-control bundle between the
//               pipeline front end (master) and fwd_hazard_ctrl (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface fwd_hazard_ctrl_if #(
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
);
    // Pipeline control
    logic              hold;
    logic              flush;
    // ID-stage instruction description
    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] id_rd;
    logic              id_rd_we;
    logic              id_is_load;
    // Controller results
    logic              stall;
    logic [1:0]        fwd_sel_a;
    logic [1:0]        fwd_sel_b;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load,
        input  stall, fwd_sel_a, fwd_sel_b, stall_cnt
    );

    modport slave (
        input  hold, flush, id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
               id_rd, id_rd_we, id_is_load,
        output stall, fwd_sel_a, fwd_sel_b, stall_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fwd_hazard_ctrl
// Description : Operand forwarding select and load-use stall controller for
//               the 16-bit pipeline. Select codes are registered so they are
//               valid while the instruction sits in EX.
//               Codes: 00 reg-file, 10 EX/MEM result, 01 MEM/WB result.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_ctrl #(
    parameter int REG_AW   = 4,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    fwd_hazard_ctrl_if.slave  bus
);

    localparam logic [1:0]       c_SEL_RF  = 2'b00;
    localparam logic [1:0]       c_SEL_EXM = 2'b10;
    localparam logic [1:0]       c_SEL_MWB = 2'b01;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // The WB slot contents are never consulted: selects are computed one
    // cycle ahead, so the instruction in MEM now is the MEM/WB source when
    // the consumer reaches EX. Only EX and MEM slots need storage.
    logic              r_ex_valid;
    logic [REG_AW-1:0] r_ex_rd;
    logic              r_ex_we;
    logic              r_ex_load;
    logic              r_mem_valid;
    logic [REG_AW-1:0] r_mem_rd;
    logic              r_mem_we;
    logic              r_mem_load;

    logic [1:0]        r_sel_a;
    logic [1:0]        r_sel_b;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_ex_wr_rs1;
    logic              w_ex_wr_rs2;
    logic              w_mem_wr_rs1;
    logic              w_mem_wr_rs2;
    logic              w_stall;
    logic              w_ex_fill;
    logic [1:0]        w_sel_a;
    logic [1:0]        w_sel_b;

    // True when a slot will write architectural register r (r0 excluded
    // when it is hardwired zero).
    function automatic logic f_writes(
        input logic              valid,
        input logic              we,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] r
    );
        return valid && we && (rd == r) && !((ZERO_REG != 0) && (r == '0));
    endfunction

    // Select priority: younger non-load EX result first, then MEM result.
    function automatic logic [1:0] f_sel(
        input logic fill,
        input logic used,
        input logic ex_wr,
        input logic ex_load,
        input logic mem_wr
    );
        if (!fill || !used)        return c_SEL_RF;
        else if (ex_wr && !ex_load) return c_SEL_EXM;
        else if (mem_wr)           return c_SEL_MWB;
        else                       return c_SEL_RF;
    endfunction

    assign w_ex_wr_rs1  = f_writes(r_ex_valid,  r_ex_we,  r_ex_rd,  bus.id_rs1);
    assign w_ex_wr_rs2  = f_writes(r_ex_valid,  r_ex_we,  r_ex_rd,  bus.id_rs2);
    assign w_mem_wr_rs1 = f_writes(r_mem_valid, r_mem_we, r_mem_rd, bus.id_rs1);
    assign w_mem_wr_rs2 = f_writes(r_mem_valid, r_mem_we, r_mem_rd, bus.id_rs2);

    // Load in EX feeding a used source cannot be forwarded in time.
    assign w_stall = bus.id_valid && !bus.flush && r_ex_load &&
                     ((bus.id_rs1_used && w_ex_wr_rs1) ||
                      (bus.id_rs2_used && w_ex_wr_rs2));

    // A real instruction enters EX only if not flushed or stalled.
    assign w_ex_fill = bus.id_valid && !bus.flush && !w_stall;

    assign w_sel_a = f_sel(w_ex_fill, bus.id_rs1_used, w_ex_wr_rs1, r_ex_load, w_mem_wr_rs1);
    assign w_sel_b = f_sel(w_ex_fill, bus.id_rs2_used, w_ex_wr_rs2, r_ex_load, w_mem_wr_rs2);

    // Advance the slot pipeline and register the selects unless frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_valid  <= 1'b0;
            r_ex_rd     <= '0;
            r_ex_we     <= 1'b0;
            r_ex_load   <= 1'b0;
            r_mem_valid <= 1'b0;
            r_mem_rd    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_load  <= 1'b0;
            r_sel_a     <= c_SEL_RF;
            r_sel_b     <= c_SEL_RF;
        end else if (!bus.hold) begin
            r_mem_valid <= r_ex_valid;
            r_mem_rd    <= r_ex_rd;
            r_mem_we    <= r_ex_we;
            r_mem_load  <= r_ex_load;
            r_ex_valid  <= w_ex_fill;
            r_ex_rd     <= bus.id_rd;
            r_ex_we     <= bus.id_rd_we;
            r_ex_load   <= bus.id_is_load;
            r_sel_a     <= w_sel_a;
            r_sel_b     <= w_sel_b;
        end
    end

    // Saturating count of cycles lost to load-use stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (!bus.hold && w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.fwd_sel_a = r_sel_a;
    assign bus.fwd_sel_b = r_sel_b;
    assign bus.stall_cnt = r_stall_cnt;

    // MEM load flag is carried for slot completeness only.
    logic w_unused;
    assign w_unused = r_mem_load;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_hazard_ctrl
// Description : Directed table-driven bench for fwd_hazard_ctrl, plus
//               hand-written hold/flush, reset and saturation sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_ctrl;

    logic clk;
    logic rst_n;

    fwd_hazard_ctrl_if #(.REG_AW(4), .CNT_W(16)) bus ();
    fwd_hazard_ctrl_if #(.REG_AW(4), .CNT_W(4))  bus_s ();

    fwd_hazard_ctrl #(.REG_AW(4), .ZERO_REG(1), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Narrow-counter copy sharing the same stimulus, for saturation.
    fwd_hazard_ctrl #(.REG_AW(4), .ZERO_REG(1), .CNT_W(4)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    assign bus_s.hold        = bus.hold;
    assign bus_s.flush       = bus.flush;
    assign bus_s.id_valid    = bus.id_valid;
    assign bus_s.id_rs1      = bus.id_rs1;
    assign bus_s.id_rs2      = bus.id_rs2;
    assign bus_s.id_rs1_used = bus.id_rs1_used;
    assign bus_s.id_rs2_used = bus.id_rs2_used;
    assign bus_s.id_rd       = bus.id_rd;
    assign bus_s.id_rd_we    = bus.id_rd_we;
    assign bus_s.id_is_load  = bus.id_is_load;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       v;
        logic [3:0] rs1;
        logic       u1;
        logic [3:0] rs2;
        logic       u2;
        logic [3:0] rd;
        logic       we;
        logic       ld;
        logic       e_stall;
        logic [1:0] e_a;
        logic [1:0] e_b;
    } vec_t;

    vec_t vecs [18];
    int   n_err;
    int   n_chk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] rs1, input logic u1,
                         input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                         input logic we, input logic ld);
        bus.id_valid    = v;
        bus.id_rs1      = rs1;
        bus.id_rs1_used = u1;
        bus.id_rs2      = rs2;
        bus.id_rs2_used = u2;
        bus.id_rd       = rd;
        bus.id_rd_we    = we;
        bus.id_is_load  = ld;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic v, input logic [3:0] rs1, input logic u1,
                                input logic [3:0] rs2, input logic u2, input logic [3:0] rd,
                                input logic we, input logic ld, input logic es,
                                input logic [1:0] ea, input logic [1:0] eb);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.we = we; t.ld = ld; t.e_stall = es; t.e_a = ea; t.e_b = eb;
        return t;
    endfunction

    initial begin
        n_err = 0;
        n_chk = 0;
        //              v  rs1 u1 rs2 u2 rd  we ld  stall a      b
        vecs[0]  = mk(1, 1,  1, 2,  1, 3,  1, 0,  0, 2'b00, 2'b00); // ADD r3
        vecs[1]  = mk(1, 3,  1, 5,  1, 4,  1, 0,  0, 2'b10, 2'b00); // SUB r4,r3,r5
        vecs[2]  = mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 2'b00, 2'b00); // NOP
        vecs[3]  = mk(1, 1,  1, 1,  1, 3,  1, 0,  0, 2'b00, 2'b00); // ADD r3
        vecs[4]  = mk(0, 0,  0, 0,  0, 0,  0, 0,  0, 2'b00, 2'b00); // NOP
        vecs[5]  = mk(1, 7,  1, 3,  1, 6,  1, 0,  0, 2'b00, 2'b01); // SUB r6,r7,r3
        vecs[6]  = mk(1, 1,  1, 2,  1, 3,  1, 0,  0, 2'b00, 2'b00); // ADD r3
        vecs[7]  = mk(1, 3,  1, 2,  1, 3,  1, 0,  0, 2'b10, 2'b00); // ADD r3,r3,r2
        vecs[8]  = mk(1, 3,  1, 3,  1, 8,  1, 0,  0, 2'b10, 2'b10); // SUB r8,r3,r3
        vecs[9]  = mk(1, 1,  1, 0,  0, 2,  1, 1,  0, 2'b00, 2'b00); // LW r2
        vecs[10] = mk(1, 2,  1, 4,  1, 9,  1, 0,  1, 2'b00, 2'b00); // ADD r9,r2,r4 stall
        vecs[11] = mk(1, 2,  1, 4,  1, 9,  1, 0,  0, 2'b01, 2'b00); // ADD reissued
        vecs[12] = mk(1, 1,  1, 0,  0, 0,  1, 0,  0, 2'b00, 2'b00); // write r0
        vecs[13] = mk(1, 0,  1, 0,  1, 5,  1, 0,  0, 2'b00, 2'b00); // read r0
        vecs[14] = mk(1, 5,  0, 9,  1, 10, 1, 0,  0, 2'b00, 2'b00); // rs1 unused
        vecs[15] = mk(1, 1,  1, 0,  0, 11, 1, 1,  0, 2'b00, 2'b00); // LW r11
        vecs[16] = mk(1, 11, 0, 1,  1, 12, 1, 0,  0, 2'b00, 2'b00); // unused load src
        vecs[17] = mk(1, 11, 1, 12, 1, 13, 1, 0,  0, 2'b01, 2'b10); // both forwards

        bus.hold  = 1'b0;
        bus.flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check("reset_stall", 32'(bus.stall), 32'd0);
        check("reset_sel_a", 32'(bus.fwd_sel_a), 32'd0);
        check("reset_sel_b", 32'(bus.fwd_sel_b), 32'd0);
        check("reset_cnt",   32'(bus.stall_cnt), 32'd0);
        #5 rst_n = 1'b1;

        // Table: one instruction per cycle, stall sampled mid-cycle,
        // selects sampled just after the edge that moves it into EX.
        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].v, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2,
                  vecs[i].rd, vecs[i].we, vecs[i].ld);
            @(negedge clk);
            check($sformatf("v%0d_stall", i), 32'(bus.stall), 32'(vecs[i].e_stall));
            tick();
            check($sformatf("v%0d_sel_a", i), 32'(bus.fwd_sel_a), 32'(vecs[i].e_a));
            check($sformatf("v%0d_sel_b", i), 32'(bus.fwd_sel_b), 32'(vecs[i].e_b));
        end
        check("table_cnt", 32'(bus.stall_cnt), 32'd1);

        // Hold freezes a pending load-use; flush then kills the consumer.
        drive(1, 13, 1, 0, 0, 2, 1, 1);                 // LW r2 <- r13 (fwd 10)
        tick();
        check("lw_sel_a", 32'(bus.fwd_sel_a), 32'd2);
        drive(1, 2, 1, 4, 1, 9, 1, 0);                  // ADD r9,r2,r4
        bus.hold = 1'b1;
        @(negedge clk);
        check("hold_stall", 32'(bus.stall), 32'd1);
        tick();
        tick();
        check("hold_sel_a", 32'(bus.fwd_sel_a), 32'd2);
        check("hold_sel_b", 32'(bus.fwd_sel_b), 32'd0);
        check("hold_cnt",   32'(bus.stall_cnt), 32'd1);
        check("hold_stall2", 32'(bus.stall), 32'd1);
        bus.hold  = 1'b0;
        bus.flush = 1'b1;
        #1;
        check("flush_stall", 32'(bus.stall), 32'd0);
        tick();
        check("flush_sel_a", 32'(bus.fwd_sel_a), 32'd0);
        check("flush_cnt",   32'(bus.stall_cnt), 32'd1);
        bus.flush = 1'b0;
        #1;
        check("post_flush_stall", 32'(bus.stall), 32'd0);
        tick();
        check("post_flush_sel_a", 32'(bus.fwd_sel_a), 32'd1);
        check("post_flush_sel_b", 32'(bus.fwd_sel_b), 32'd0);

        // Reset asserted while a stall is pending clears everything at once.
        drive(1, 9, 1, 0, 0, 2, 1, 1);                  // LW r2 <- r9
        tick();
        check("lw2_sel_a", 32'(bus.fwd_sel_a), 32'd2);
        drive(1, 2, 1, 0, 0, 9, 1, 0);
        @(negedge clk);
        check("pre_rst_stall", 32'(bus.stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_stall", 32'(bus.stall), 32'd0);
        check("mid_rst_sel_a", 32'(bus.fwd_sel_a), 32'd0);
        check("mid_rst_sel_b", 32'(bus.fwd_sel_b), 32'd0);
        check("mid_rst_cnt",   32'(bus.stall_cnt), 32'd0);
        check("mid_rst_cnt_s", 32'(bus_s.stall_cnt), 32'd0);
        #2 rst_n = 1'b1;
        tick();
        check("after_rst_sel_a", 32'(bus.fwd_sel_a), 32'd0);

        // 2^4+3 load-use pairs: narrow counter saturates, wide one counts.
        for (int k = 0; k < 19; k++) begin
            drive(1, 1, 1, 0, 0, 2, 1, 1);
            tick();
            drive(1, 2, 1, 0, 0, 9, 1, 0);
            tick();
        end
        check("sat_cnt_wide",   32'(bus.stall_cnt),   32'd19);
        check("sat_cnt_narrow", 32'(bus_s.stall_cnt), 32'hF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Forwarding and load-use hazard controller for the 16-bit pipeline.
- Tracks destination registers of in-flight instructions across the EX, MEM and WB slots.
- Produces registered 2-bit select codes for the two EX-stage operand muxes (A and B), plus a one-cycle load-use stall.
- Select encoding: 00 = register-file operand, 10 = EX/MEM result, 01 = MEM/WB result; 11 is never driven.

Parameters:
- REG_AW, 4: register address width (16 architectural registers).
- ZERO_REG, 1: when 1, register 0 is hardwired zero and is never a forwarding source.
- CNT_W, 16: width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hold  in  1  global pipeline freeze; all internal state is held.
- flush  in  1  kill the instruction currently in ID; a bubble enters EX.
- id_valid  in  1  ID slot holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source register addresses of the ID instruction.
- id_rs1_used, id_rs2_used  in  1  the corresponding source is actually read.
- id_rd  in  REG_AW  destination register of the ID instruction.
- id_rd_we  in  1  the ID instruction writes id_rd.
- id_is_load  in  1  the ID instruction is a memory load.
- stall  out  1  load-use stall: ID and IF must not advance this cycle.
- fwd_sel_a, fwd_sel_b  out  2  registered select codes for the EX operand muxes.
- stall_cnt  out  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- Internal slots:
  - EX = {valid, rd, we, load}.
  - MEM = {valid, rd, we, load}.
  - WB = {valid, rd, we}.
- A slot "writes r" when: valid & we & rd==r & !(ZERO_REG & r==0).
- Reset (async, rst_n=0):
  - All slot valid bits = 0.
  - fwd_sel_a = fwd_sel_b = 2'b00.
  - stall_cnt = 0.
  - stall is 0 because all slots are invalid.
- stall is combinational. It is 1 when id_valid & !flush & EX.load & EX writes a register that the ID instruction uses (rs1 with rs1_used, or rs2 with rs2_used).
- Update on each rising clk edge, in priority order:
  - hold=1: nothing changes, outputs hold. hold overrides flush and stall.
  - Otherwise the slots advance: WB<=MEM, MEM<=EX.
  - EX loads, in priority order:
    - a bubble (valid=0) if flush=1;
    - else a bubble if stall=1;
    - else the ID fields, with valid=id_valid.
- Select computation, per operand, evaluated against the slots that will be MEM and WB next cycle (current EX and current MEM):
  - If the source is unused, or the new EX entry is a bubble: 00.
  - Else if current EX writes the source and is not a load: 10.
  - Else if current MEM writes the source: 01.
  - Else: 00.
  - Both operands are evaluated independently; rs1==rs2 yields identical codes.
- When current EX and current MEM both write the same register, the younger instruction (EX) wins: code 10.
- Stall cycle:
  - The bubble is captured into EX and the ID instruction is held by upstream.
  - On the next cycle the load sits in MEM, so re-evaluation selects 01 for that operand; stall then deasserts.
  - Stall is therefore exactly 1 cycle per load-use pair.
- fwd_sel_a and fwd_sel_b update only on non-hold edges. They equal the recomputed codes, or 00 when a bubble is inserted.
- stall_cnt increments on each non-hold edge with stall=1 and saturates at all-ones.
- Reset asserted mid-stall: stall drops immediately and all state clears.
- Latency: select codes are valid in the same cycle the instruction occupies EX (one clock after ID).

Test Plan:
- Reset: assert rst_n=0 mid-stream -> fwd_sel_a/b=00, stall=0, stall_cnt=0 immediately, without waiting for clk.
- EX/MEM forward: ADD r3 then SUB r4,r3,r5 on back-to-back cycles -> SUB in EX has fwd_sel_a=10, fwd_sel_b=00.
- MEM/WB forward and priority:
  - ADD r3; NOP; SUB using rs2=r3 -> fwd_sel_b=01.
  - ADD r3; ADD r3; SUB using r3 -> 10 (younger instruction wins).
- Load-use: LW r2 followed by ADD using rs1=r2 -> stall=1 for exactly one cycle, then ADD reaches EX with fwd_sel_a=01; stall_cnt=1.
- Zero register and unused sources:
  - Writer of r0 followed by a reader of r0 -> 00.
  - rs1 matches a prior rd but id_rs1_used=0 -> 00, no stall.
- Hold/flush interaction:
  - hold=1 during a pending load-use -> all outputs frozen and stall_cnt unchanged.
  - flush=1 with the same ID instruction -> stall=0 and a bubble enters EX (next selects 00).
  - Force 2^CNT_W+3 stalls -> stall_cnt saturates at 16'hFFFF.
